set_assoc_cache: RTL and testbench
==================================

# set_assoc_cache

Parametrised N-way set-associative, write-through, write-allocate cache controller with true-LRU replacement and an integrated miss-fill state machine. It sits between the pipeline memory stage (or fetch stage) and the multi-cycle main memory. It supersedes the fixed 2-way/64-set data cache by generalising ways, sets, block size and widths. It also adds in-order block refill and hit/miss performance counters.

## Interface
- ADDR_W, 16, byte address width
- WORD_W, 16, data word width (2 bytes; address bit 0 ignored)
- SETS, 64, number of sets (power of two)
- WAYS, 2, associativity (power of two, ≥2)
- BLK_WORDS, 8, words per block (power of two, ≥2)
- CNT_W, 16, perf counter width

Derived widths:
- OFF_W = log2(BLK_WORDS)+1
- IDX_W = log2(SETS)
- TAG_W = ADDR_W−IDX_W−OFF_W (defaults: 4/6/6)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  access request; cpu_addr/cpu_we/cpu_wdata held stable until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  WORD_W  store data
- cpu_rdata  out  WORD_W  load data, valid when cpu_req&cpu_ready&~cpu_we
- cpu_ready  out  1  access completes this cycle; low = stall
- mem_rd  out  1  one-cycle read request for word at mem_addr
- mem_wr  out  1  one-cycle write-through request
- mem_addr  out  ADDR_W  word-aligned memory address
- mem_wdata  out  WORD_W  write data
- mem_rdata  in  WORD_W  read return data
- mem_rvalid  in  1  read return strobe; returns in request order, ≥1 cycle after mem_rd
- hit_cnt  out  CNT_W  saturating count of hit completions
- miss_cnt  out  CNT_W  saturating count of misses

## Operation
Address split: tag = addr[ADDR_W−1 : OFF_W+IDX_W], index = addr[OFF_W+IDX_W−1 : OFF_W], word = addr[OFF_W−1 : 1].

Storage:
- Per way/set: valid bit, tag, BLK_WORDS data words.
- Per set: one log2(WAYS)-bit age per way. Ages always form a permutation of 0..WAYS−1; 0 = MRU.
- Tag/data arrays have asynchronous read and synchronous write. Not reset.

FSM states: LOOKUP, FILL, INSTALL.

LOOKUP:
- Hit condition: valid & tag match in any way (at most one way matches).
- Load hit: cpu_ready=1, cpu_rdata = hit word, same cycle.
- Store hit: write word into hit way at the clock edge; drive mem_wr=1, mem_addr={cpu_addr[ADDR_W−1:1],1'b0}, mem_wdata=cpu_wdata; cpu_ready=1.
- Any hit: LRU update (hit way → age 0; ways with age < old age increment), hit_cnt+1.
- Miss (cpu_req & no hit): cpu_ready=0, miss_cnt+1.
  - Latch victim way: lowest-index invalid way, else the way with age WAYS−1.
  - Latch block base address; → FILL.
- cpu_req=0: no action, cpu_ready=0.

FILL:
- Issue counter runs 0..BLK_WORDS−1; one mem_rd per cycle, mem_addr = block base + 2·count.
- Receive counter writes each mem_rvalid word into the victim way, word = receive count.
- Victim valid bit is cleared on FILL entry.
- After BLK_WORDS words are received → INSTALL.

INSTALL:
- Write the tag and set valid=1 for the victim; LRU update with victim as the accessed way.
- → LOOKUP, where the held request hits. That hit is counted in hit_cnt as well.
- Store misses are thereby written through on the hit cycle (write-allocate).

Rules:
- mem_rd and mem_wr are never asserted together.
- mem_rvalid outside FILL is ignored.
- A cpu_req drop during FILL does not abort the fill; the block is still installed.
- Counters saturate at 2^CNT_W−1.

## Timing
- Reset values: state=LOOKUP, all valid=0, ages of set s way w = w, counters 0.
- Outputs during reset: cpu_ready=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, cpu_rdata=0.
- Hit latency: 0 extra cycles (ready in the request cycle).
- Miss latency with memory return latency L: 1 (lookup) + BLK_WORDS issue cycles, with the last data arriving at issue-end+L−1, then 1 (INSTALL) + 1 (hit).
  - BLK_WORDS=8, L=4: ready asserts on cycle 13 after the request cycle (cycle 0).
- rst mid-FILL: next cycle LOOKUP, all lines invalid, mem_rd low. Memory shares rst, so no stale returns arrive.

## Test plan
- Reset, then load 0x0010: miss; mem_rd ×8 at 0x0010..0x001E; with L=4, cpu_ready asserts on cycle 13; miss_cnt=1, hit_cnt=1.
- Load 0x0016 after that fill → hit in the same cycle, returning the memory word of 0x0016; no mem_rd.
- Store 0x1234 to 0x0012 (line resident) → mem_wr=1, mem_addr=0x0012, mem_wdata=0x1234, same cycle; a later load of 0x0012 returns 0x1234.
- WAYS=2: fill tags A, B in set 5; touch A; miss on C in set 5 → B evicted; then A hits and B misses.
- Store miss to 0x0400 with data 0xBEEF → 8-word fill, then a single mem_wr of 0xBEEF to 0x0400; a later load of 0x0400 hits with 0xBEEF.
- Assert rst on the 3rd FILL cycle → cpu_ready=0, mem_rd=0 next cycle; a re-access of the same address misses and the full fill repeats.

Source files
------------

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-through / write-allocate cache with true-LRU
// replacement, in-order block refill FSM and saturating hit/miss counters.

module set_assoc_cache_way #(
   parameter int TAG_W  = 6,
   parameter int IDX_W  = 6,
   parameter int WSEL_W = 3,
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [TAG_W-1:0]  rd_tag,
   input  logic [WSEL_W-1:0] rd_word,
   output logic              line_vld,
   output logic              hit,
   output logic [WORD_W-1:0] rdata,
   input  logic              inv_en,
   input  logic              tag_we,
   input  logic              data_we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [WSEL_W-1:0] wr_word,
   input  logic [WORD_W-1:0] wr_data
);
   localparam int SETS = 1 << IDX_W;
   localparam int BLK  = 1 << WSEL_W;

   logic [SETS-1:0]              valid;
   logic [TAG_W-1:0]             tags [SETS];
   logic [BLK-1:0][WORD_W-1:0]   data [SETS];

   always_ff @(posedge clk) begin
      if (rst) valid <= '0;
      else begin
         if (inv_en) valid[wr_idx] <= 1'b0;
         if (tag_we) valid[wr_idx] <= 1'b1;
      end
   end

   // tag/data storage is intentionally not reset; valid bits gate it
   always_ff @(posedge clk) begin
      if (tag_we)  tags[wr_idx] <= wr_tag;
      if (data_we) data[wr_idx][wr_word] <= wr_data;
   end

   assign line_vld = valid[rd_idx];
   assign hit      = line_vld && (tags[rd_idx] == rd_tag);
   assign rdata    = data[rd_idx][rd_word];
endmodule

module set_assoc_cache #(
   parameter int ADDR_W    = 16,
   parameter int WORD_W    = 16,
   parameter int SETS      = 64,
   parameter int WAYS      = 2,
   parameter int BLK_WORDS = 8,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [WORD_W-1:0] cpu_wdata,
   output logic [WORD_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);
   localparam int WSEL_W = $clog2(BLK_WORDS);
   localparam int OFF_W  = WSEL_W + 1;
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int WAY_W  = $clog2(WAYS);
   localparam int AGE_W  = $clog2(WAYS);

   typedef enum logic [1:0] {S_LOOKUP, S_FILL, S_INSTALL} state_t;

   state_t                       state, state_n;
   logic [WAY_W-1:0]             victim, victim_sel, hit_way, lru_way;
   logic [TAG_W-1:0]             fill_tag;
   logic [IDX_W-1:0]             fill_idx, wr_idx, lru_idx;
   logic [WSEL_W:0]              iss_cnt;
   logic [WSEL_W-1:0]            rcv_cnt, wr_word;
   logic [WORD_W-1:0]            wr_data;
   logic [WAYS-1:0][AGE_W-1:0]   ages [SETS];

   logic [WAYS-1:0]              way_hit, way_vld, inv_en, tag_we, data_we;
   logic [WAYS-1:0][WORD_W-1:0]  way_rdata;
   logic                         hit_any, lk_hit, lk_miss, fill_we, install, lru_en;
   logic                         unused_addr_lsb;

   wire [TAG_W-1:0]  cpu_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
   wire [IDX_W-1:0]  cpu_idx  = cpu_addr[OFF_W +: IDX_W];
   wire [WSEL_W-1:0] cpu_word = cpu_addr[1 +: WSEL_W];
   assign unused_addr_lsb = cpu_addr[0];

   genvar gw;
   generate
      for (gw = 0; gw < WAYS; gw++) begin : g_way
         set_assoc_cache_way #(
            .TAG_W(TAG_W), .IDX_W(IDX_W), .WSEL_W(WSEL_W), .WORD_W(WORD_W)
         ) u_way (
            .clk(clk), .rst(rst),
            .rd_idx(cpu_idx), .rd_tag(cpu_tag), .rd_word(cpu_word),
            .line_vld(way_vld[gw]), .hit(way_hit[gw]), .rdata(way_rdata[gw]),
            .inv_en(inv_en[gw]), .tag_we(tag_we[gw]), .data_we(data_we[gw]),
            .wr_idx(wr_idx), .wr_tag(fill_tag), .wr_word(wr_word), .wr_data(wr_data)
         );
         assign inv_en[gw]  = lk_miss && (victim_sel == WAY_W'(gw));
         assign tag_we[gw]  = install && (victim == WAY_W'(gw));
         assign data_we[gw] = (mem_wr && way_hit[gw]) || (fill_we && (victim == WAY_W'(gw)));
      end
   endgenerate

   assign hit_any = |way_hit;
   assign lk_hit  = !rst && (state == S_LOOKUP) && cpu_req && hit_any;
   assign lk_miss = !rst && (state == S_LOOKUP) && cpu_req && !hit_any;
   assign fill_we = !rst && (state == S_FILL) && mem_rvalid;
   assign install = !rst && (state == S_INSTALL);

   assign wr_idx  = (state == S_LOOKUP) ? cpu_idx   : fill_idx;
   assign wr_word = (state == S_LOOKUP) ? cpu_word  : rcv_cnt;
   assign wr_data = (state == S_LOOKUP) ? cpu_wdata : mem_rdata;

   assign lru_en  = lk_hit || install;
   assign lru_idx = lk_hit ? cpu_idx : fill_idx;
   assign lru_way = lk_hit ? hit_way : victim;

   // victim: oldest way, overridden by the lowest-index invalid way
   always_comb begin
      hit_way    = '0;
      victim_sel = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (way_hit[w]) hit_way = WAY_W'(w);
         if (ages[cpu_idx][w] == AGE_W'(WAYS - 1)) victim_sel = WAY_W'(w);
      end
      for (int w = WAYS - 1; w >= 0; w--)
         if (!way_vld[w]) victim_sel = WAY_W'(w);
   end

   always_comb begin
      state_n   = state;
      cpu_ready = lk_hit;
      cpu_rdata = '0;
      mem_wr    = lk_hit && cpu_we;
      mem_rd    = !rst && (state == S_FILL) && !iss_cnt[WSEL_W];
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         S_LOOKUP:  if (lk_miss) state_n = S_FILL;
         S_FILL:    if (fill_we && (rcv_cnt == WSEL_W'(BLK_WORDS - 1))) state_n = S_INSTALL;
         S_INSTALL: state_n = S_LOOKUP;
         default:   state_n = S_LOOKUP;
      endcase
      if (lk_hit && !cpu_we) cpu_rdata = way_rdata[hit_way];
      if (mem_wr) begin
         mem_addr  = {cpu_addr[ADDR_W-1:1], 1'b0};
         mem_wdata = cpu_wdata;
      end else if (mem_rd) begin
         mem_addr  = {fill_tag, fill_idx, iss_cnt[WSEL_W-1:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_LOOKUP;
         victim   <= '0;
         fill_tag <= '0;
         fill_idx <= '0;
         iss_cnt  <= '0;
         rcv_cnt  <= '0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               ages[s][w] <= AGE_W'(w);
      end else begin
         state <= state_n;
         if (lk_miss) begin
            victim   <= victim_sel;
            fill_tag <= cpu_tag;
            fill_idx <= cpu_idx;
            iss_cnt  <= '0;
            rcv_cnt  <= '0;
         end
         if (mem_rd)  iss_cnt <= iss_cnt + (WSEL_W + 1)'(1);
         if (fill_we) rcv_cnt <= rcv_cnt + WSEL_W'(1);
         if (lk_hit  && (hit_cnt  != '1)) hit_cnt  <= hit_cnt  + CNT_W'(1);
         if (lk_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
         // accessed way becomes MRU; younger ways age by one
         if (lru_en)
            for (int w = 0; w < WAYS; w++) begin
               if (WAY_W'(w) == lru_way)
                  ages[lru_idx][w] <= '0;
               else if (ages[lru_idx][w] < ages[lru_idx][lru_way])
                  ages[lru_idx][w] <= ages[lru_idx][w] + AGE_W'(1);
            end
      end
   end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: table of accesses against a memory
// model with 4-cycle read latency, plus a reset-during-fill sequence.

module tb_set_assoc_cache;
   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_ready, mem_rd, mem_wr, mem_rvalid;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, hit_cnt, miss_cnt;

   always #5 clk = ~clk;

   set_assoc_cache dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   // memory: word at byte address A initialised to A ^ 0xC3C3
   logic [15:0] mem_words [32768];
   logic [2:0]  d_vld;
   logic [15:0] d_dat [3];

   always @(posedge clk) begin
      if (rst) d_vld <= '0;
      else begin
         d_vld    <= {d_vld[1:0], mem_rd};
         d_dat[0] <= mem_words[mem_addr[15:1]];
         d_dat[1] <= d_dat[0];
         d_dat[2] <= d_dat[1];
         if (mem_wr) mem_words[mem_addr[15:1]] <= mem_wdata;
      end
   end
   assign mem_rvalid = d_vld[2];
   assign mem_rdata  = d_dat[2];

   // mid-cycle bus monitor
   logic [15:0] rd_log[$];
   int          wr_n, overlap;
   logic [15:0] wr_addr, wr_data;
   always @(negedge clk) begin
      #3;
      if (mem_rd) rd_log.push_back(mem_addr);
      if (mem_wr) begin wr_n++; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (mem_rd && mem_wr) overlap++;
   end

   int errors = 0, checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_fill(input string name, input logic [15:0] base);
      chk({name, "_nrd"}, rd_log.size(), 8);
      for (int k = 0; k < rd_log.size() && k < 8; k++)
         chk($sformatf("%s_rdaddr%0d", name, k), rd_log[k], base + 16'(2 * k));
   endtask

   task automatic run_access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                             output int lat, output logic [15:0] rd);
      rd_log.delete();
      wr_n = 0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      lat = 0;
      #2;
      while (!cpu_ready && lat < 100) begin @(negedge clk); #2; lat++; end
      rd = cpu_rdata;
      if (!cpu_ready) lat = -1;
      @(negedge clk);
      cpu_req = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [15:0] addr, wdata, exp_rd;
      int          exp_lat;
      logic [15:0] exp_hit, exp_miss;
   } vec_t;

   vec_t vt[13];

   initial begin
      int          lat;
      logic [15:0] rd;

      for (int i = 0; i < 32768; i++) mem_words[i] = 16'(i << 1) ^ 16'hC3C3;
      wr_n = 0; overlap = 0;
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

      //          we    addr      wdata     rdata     lat hit  miss
      vt[0]  = '{1'b0, 16'h0010, 16'h0000, 16'hC3D3, 13,  1,  1};
      vt[1]  = '{1'b0, 16'h0016, 16'h0000, 16'hC3D5,  0,  2,  1};
      vt[2]  = '{1'b1, 16'h0012, 16'h1234, 16'h0000,  0,  3,  1};
      vt[3]  = '{1'b0, 16'h0012, 16'h0000, 16'h1234,  0,  4,  1};
      vt[4]  = '{1'b0, 16'h1050, 16'h0000, 16'hD393, 13,  5,  2};
      vt[5]  = '{1'b0, 16'h2050, 16'h0000, 16'hE393, 13,  6,  3};
      vt[6]  = '{1'b0, 16'h1054, 16'h0000, 16'hD397,  0,  7,  3};
      vt[7]  = '{1'b0, 16'h3050, 16'h0000, 16'hF393, 13,  8,  4};
      vt[8]  = '{1'b0, 16'h1050, 16'h0000, 16'hD393,  0,  9,  4};
      vt[9]  = '{1'b0, 16'h2050, 16'h0000, 16'hE393, 13, 10,  5};
      vt[10] = '{1'b1, 16'h0400, 16'hBEEF, 16'h0000, 13, 11,  6};
      vt[11] = '{1'b0, 16'h0400, 16'h0000, 16'hBEEF,  0, 12,  6};
      vt[12] = '{1'b0, 16'h0010, 16'h0000, 16'hC3D3,  0, 13,  6};

      // outputs stay quiet while reset is held, even with a request pending
      repeat (2) @(negedge clk);
      cpu_req = 1'b1; cpu_addr = 16'h0010;
      #2;
      chk("rst_ready", cpu_ready, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rdata", cpu_rdata, 0);
      @(negedge clk);
      cpu_req = 1'b0; rst = 1'b0;
      #2;
      chk("rst_hit_cnt", hit_cnt, 0);
      chk("rst_miss_cnt", miss_cnt, 0);

      foreach (vt[i]) begin
         run_access(vt[i].we, vt[i].addr, vt[i].wdata, lat, rd);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
         if (!vt[i].we) chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
         if (vt[i].exp_lat != 0) chk_fill($sformatf("v%0d", i), vt[i].addr & 16'hFFF0);
         else chk($sformatf("v%0d_nrd", i), rd_log.size(), 0);
         chk($sformatf("v%0d_nwr", i), wr_n, vt[i].we ? 1 : 0);
         if (vt[i].we) begin
            chk($sformatf("v%0d_wr_addr", i), wr_addr, vt[i].addr);
            chk($sformatf("v%0d_wr_data", i), wr_data, vt[i].wdata);
         end
         chk($sformatf("v%0d_hit_cnt", i), hit_cnt, vt[i].exp_hit);
         chk($sformatf("v%0d_miss_cnt", i), miss_cnt, vt[i].exp_miss);
      end

      // reset on the third FILL cycle, request held: the fill restarts from scratch
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0800;
      #2;
      chk("mf_first_ready", cpu_ready, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rd_log.delete();
      #2;
      chk("mf_ready_after_rst", cpu_ready, 0);
      chk("mf_mem_rd_after_rst", mem_rd, 0);
      lat = 0;
      while (!cpu_ready && lat < 100) begin @(negedge clk); #2; lat++; end
      chk("mf_lat", 32'(cpu_ready ? lat : -1), 13);
      chk("mf_rdata", cpu_rdata, 16'hCBC3);
      chk_fill("mf", 16'h0800);
      @(negedge clk);
      cpu_req = 1'b0;
      #2;
      chk("mf_hit_cnt", hit_cnt, 1);
      chk("mf_miss_cnt", miss_cnt, 1);

      chk("rd_wr_overlap", overlap, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
